// File: rtl/sap1_pkg.sv
// sap1_pkg: shared opcodes, control-bit indices and named control words for the SAP-1 controller
package sap1_pkg;
   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;
   localparam int CP   = 11;
   localparam int EP   = 10;
   localparam int LM_N = 9;
   localparam int CE_N = 8;
   localparam int LI_N = 7;
   localparam int EI_N = 6;
   localparam int LA_N = 5;
   localparam int EA   = 4;
   localparam int SU   = 3;
   localparam int EU   = 2;
   localparam int LB_N = 1;
   localparam int LO_N = 0;
   localparam logic [11:0] CW_IDLE     = 12'h3E3;
   localparam logic [11:0] CW_FETCH_T1 = 12'h5E3;
   localparam logic [11:0] CW_FETCH_T2 = 12'hBE3;
   localparam logic [11:0] CW_FETCH_T3 = 12'h263;
   localparam logic [11:0] CW_ADDR_T4  = 12'h1A3;
   localparam logic [11:0] CW_LDA_T5   = 12'h2C3;
   localparam logic [11:0] CW_ALU_T5   = 12'h2E1;
   localparam logic [11:0] CW_ADD_T6   = 12'h3C7;
   localparam logic [11:0] CW_SUB_T6   = 12'h3CF;
   localparam logic [11:0] CW_OUT_T4   = 12'h3F2;
endpackage

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter: one-hot six-state ring (bit0 = T1 .. bit5 = T6)
//   clk, reset (sync, active-high -> T1), advance (step one state), restart (force T1), t_state (one-hot out)
module sap1_ring_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       advance,
   input  logic       restart,
   output logic [5:0] t_state
);
   always_ff @(posedge clk)
      if (reset || restart) t_state <= 6'b000001;
      else if (advance) t_state <= {t_state[4:0], t_state[5]};
endmodule

// File: rtl/sap1_controller.sv
// sap1_controller: SAP-1 controller-sequencer, decodes ring state and opcode into the control word
//   clk, reset (sync, active-high), opcode[3:0] (IR upper nibble), control_word[11:0], t_state[5:0], halted
//   Option SAP1_CTRL_SKIP_NOP_EN: return to T1 right after an instruction's last active state
module sap1_controller
   import sap1_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  opcode,
   output logic [11:0] control_word,
   output logic [5:0]  t_state,
   output logic        halted
);
   logic is_lda, is_add, is_sub, is_out, is_hlt, is_alu, hlt_now, advance, restart;
   assign is_lda = opcode == OP_LDA;
   assign is_add = opcode == OP_ADD;
   assign is_sub = opcode == OP_SUB;
   assign is_out = opcode == OP_OUT;
   assign is_hlt = opcode == OP_HLT;
   assign is_alu = is_add || is_sub;
   // HLT freezes the ring at T4 on the same edge that sets halted
   assign hlt_now = t_state[3] && is_hlt;
   assign advance = !halted && !hlt_now;
`ifdef SAP1_CTRL_SKIP_NOP_EN
   // LDA ends after T5; OUT and NOP end after T4
   assign restart = !halted && ((t_state[4] && is_lda) || (t_state[3] && !is_lda && !is_alu && !is_hlt));
`else
   assign restart = 1'b0;
`endif
   sap1_ring_counter u_ring (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .restart (restart),
      .t_state (t_state)
   );
   always_ff @(posedge clk)
      if (reset) halted <= 1'b0;
      else if (hlt_now) halted <= 1'b1;
   // opcode only participates from T4 onward, so IR changes during fetch are invisible
   always_comb
      control_word = halted    ? CW_IDLE :
                     t_state[0] ? CW_FETCH_T1 :
                     t_state[1] ? CW_FETCH_T2 :
                     t_state[2] ? CW_FETCH_T3 :
                     t_state[3] ? (is_lda || is_alu ? CW_ADDR_T4 : is_out ? CW_OUT_T4 : CW_IDLE) :
                     t_state[4] ? (is_lda ? CW_LDA_T5 : is_alu ? CW_ALU_T5 : CW_IDLE) :
                     t_state[5] ? (is_add ? CW_ADD_T6 : is_sub ? CW_SUB_T6 : CW_IDLE) :
                     CW_IDLE;
endmodule

// File: tb/tb_sap1_controller.sv
// tb_sap1_controller: directed self-checking bench for sap1_controller
module tb_sap1_controller;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  opcode = 4'h0;
   logic [11:0] control_word;
   logic [5:0]  t_state;
   logic        halted;
   int checks = 0;
   int failures = 0;

   sap1_controller dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .control_word (control_word),
      .t_state      (t_state),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_t1(input string tag);
      chk({tag, "_ts"}, {6'b0, t_state}, 12'h001);
      chk({tag, "_halt"}, {11'b0, halted}, 12'h000);
      chk({tag, "_cw"}, control_word, 12'h5E3);
   endtask

   task automatic run_to_t1(input string tag);
      for (int i = 0; i < 8 && t_state != 6'b000001; i++) tick();
      chk({tag, "_to_t1"}, {6'b0, t_state}, 12'h001);
   endtask

   // expected words packed T1 first
   task automatic run_instr(input string tag, input logic [3:0] op, input logic [71:0] exp);
      opcode = op;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("%s_cw_T%0d", tag, i + 1), control_word, exp[71 - 12*i -: 12]);
         chk($sformatf("%s_ts_T%0d", tag, i + 1), {6'b0, t_state}, 12'(1 << i));
         chk($sformatf("%s_lb_T%0d", tag, i + 1), {11'b0, control_word[1]},
             (i == 4 && (op == 4'h1 || op == 4'h2)) ? 12'h000 : 12'h001);
         tick();
      end
   endtask

   task automatic count_instr(input string tag, input logic [3:0] op, input int exp_cycles);
      int n;
      opcode = op;
      n = 0;
      do begin
         tick();
         n++;
      end while (t_state != 6'b000001 && n < 20);
      chk({tag, "_cycles"}, 12'(n), 12'(exp_cycles));
   endtask

   initial begin
      tick();
      reset = 1'b0;
      chk_t1("reset");
`ifndef SAP1_CTRL_SKIP_NOP_EN
      run_instr("lda0", 4'h0, {12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3});
      run_instr("lda1", 4'h0, {12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3});
      run_instr("add",  4'h1, {12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3C7});
      run_instr("sub",  4'h2, {12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3CF});
      run_instr("out",  4'hE, {12'h5E3, 12'hBE3, 12'h263, 12'h3F2, 12'h3E3, 12'h3E3});
      run_instr("nop",  4'h7, {12'h5E3, 12'hBE3, 12'h263, 12'h3E3, 12'h3E3, 12'h3E3});
`else
      count_instr("skip_lda", 4'h0, 5);
      count_instr("skip_out", 4'hE, 4);
      count_instr("skip_nop", 4'h9, 4);
      count_instr("skip_add", 4'h1, 6);
`endif
      opcode = 4'h0;
      tick();
      opcode = 4'hE;
      chk("chg_T2", control_word, 12'hBE3);
      tick();
      chk("chg_T3", control_word, 12'h263);
      tick();
      chk("chg_T4", control_word, 12'h3F2);
      run_to_t1("chg");
      opcode = 4'h1;
      for (int i = 0; i < 4; i++) tick();
      chk("rst_add_T5", control_word, 12'h2E1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_t1("rst_add");
      tick();
      chk("rst_add_next", control_word, 12'hBE3);
      run_to_t1("pre_hlt");
      opcode = 4'hF;
      for (int i = 0; i < 3; i++) tick();
      chk("hlt_T4_cw", control_word, 12'h3E3);
      chk("hlt_T4_ts", {6'b0, t_state}, 12'h008);
      chk("hlt_T4_halt", {11'b0, halted}, 12'h000);
      tick();
      chk("hlt_set", {11'b0, halted}, 12'h001);
      for (int i = 0; i < 20; i++) begin
         opcode = 4'($urandom_range(0, 15));
         tick();
         chk($sformatf("hlt_hold_cw%0d", i), control_word, 12'h3E3);
         chk($sformatf("hlt_hold_ts%0d", i), {6'b0, t_state}, 12'h008);
         chk($sformatf("hlt_hold_h%0d", i), {11'b0, halted}, 12'h001);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      opcode = 4'h0;
      chk_t1("rst_hlt");
      tick();
      chk("rst_hlt_next", control_word, 12'hBE3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
